// File: rtl/param_transmitter_if.sv
// Handshake and serial-line bundle between the TX buffer and the UART transmit engine.
interface param_transmitter_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 txValid;
  logic [DATA_BITS-1:0] txData;
  logic                 txReady;
  logic                 transmitOutput;
  logic                 busy;
  logic                 done;

  // Buffer side: offers bytes and observes the engine.
  modport master (
    output txValid, txData,
    input  txReady, transmitOutput, busy, done
  );

  // Engine side.
  modport slave (
    input  txValid, txData,
    output txReady, transmitOutput, busy, done
  );
endinterface

// File: rtl/param_transmitter.sv
// Parametrised UART transmit engine with internal bit-period divider and back-to-back frames.
module param_transmitter #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic                clk,
  input logic                rst,
  param_transmitter_if.slave bus
);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              PAR_ODD   = 1'(PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t               state_q, state_n;
  logic [BAUD_W-1:0]    baud_q,  baud_n;
  logic [BIT_W-1:0]     bit_q,   bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q,   par_n;
  logic                 line_q,  line_n;
  logic                 busy_q,  busy_n;
  logic                 done_q,  done_n;
  logic                 ready_c;
  logic                 accept_c;
  logic                 tick_c;
  logic                 load_c;

  // Ready in IDLE or on the last stop-bit cycle (done_q marks it); forced low during reset.
  assign ready_c  = rst & ((state_q == S_IDLE) | done_q);
  assign accept_c = bus.txValid & ready_c;

  assign bus.txReady        = ready_c;
  assign bus.transmitOutput = line_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      line_q  <= line_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next state: baud divider paces every bit; acceptance loads data and parity.
  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    load_c  = 1'b0;
    tick_c  = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_n = tick_c ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (accept_c) begin
          state_n = S_START;
          load_c  = 1'b1;
        end
      end
      S_START: begin
        if (tick_c) begin
          state_n = S_DATA;
          bit_n   = '0;
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_n = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      S_PAR: begin
        if (tick_c) begin
          state_n = S_STOP;
          bit_n   = '0;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (bit_q == STOP_LAST) begin
            bit_n = '0;
            if (accept_c) begin
              state_n = S_START;
              load_c  = 1'b1;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (load_c) begin
      shift_n = bus.txData;
      par_n   = (^bus.txData) ^ PAR_ODD;
    end
  end

  // Output decode from next-state values so the line and flags are registered.
  always_comb begin
    line_n = 1'b1;
    case (state_n)
      S_START: line_n = 1'b0;
      S_DATA:  line_n = shift_n[0];
      S_PAR:   line_n = par_n;
      default: line_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_STOP) && (bit_n == STOP_LAST) && (baud_n == BAUD_LAST);
  end
endmodule

// File: tb/tb_param_transmitter.sv
// Self-checking bench: directed frame table, hand sequences, and random traffic against a queue model.
module tb_param_transmitter;
  localparam int NI = 5;
  localparam int DB_C  [NI] = '{8, 8, 8, 7, 9};
  localparam int PAR_C [NI] = '{0, 2, 1, 0, 1};
  localparam int SB_C  [NI] = '{1, 1, 1, 2, 2};
  localparam int CPB_C [NI] = '{4, 4, 4, 3, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       valid   [NI];
  logic [8:0] data    [NI];
  logic       line_s  [NI];
  logic       busy_s  [NI];
  logic       done_s  [NI];
  logic       ready_s [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    param_transmitter_if #(.DATA_BITS(DB_C[g])) bus ();
    assign bus.txValid = valid[g];
    assign bus.txData  = data[g][DB_C[g]-1:0];
    assign line_s[g]   = bus.transmitOutput;
    assign busy_s[g]   = bus.busy;
    assign done_s[g]   = bus.done;
    assign ready_s[g]  = bus.txReady;
    param_transmitter #(
      .DATA_BITS   (DB_C[g]),
      .PARITY      (PAR_C[g]),
      .STOP_BITS   (SB_C[g]),
      .CLKS_PER_BIT(CPB_C[g])
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  typedef struct {
    int         inst;
    logic [8:0] dat;
    logic [15:0] bits;   // expected line level per bit period, first bit in [0]
    int         nbits;
  } vec_t;

  typedef struct packed {
    logic lvl;
    logic fin;
  } slot_t;

  slot_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs(input int i);
    return {line_s[i], busy_s[i], done_s[i], ready_s[i]};
  endfunction

  // Reference frame: start, data LSB first, optional parity, stop bits; each held CPB cycles.
  task automatic push_frame(input int i, input logic [8:0] d);
    logic b[$];
    logic p;
    p = 1'b0;
    b.push_back(1'b0);
    for (int k = 0; k < DB_C[i]; k++) begin
      b.push_back(d[k]);
      p = p ^ d[k];
    end
    if (PAR_C[i] != 0) b.push_back((PAR_C[i] == 1) ? ~p : p);
    for (int k = 0; k < SB_C[i]; k++) b.push_back(1'b1);
    for (int k = 0; k < b.size(); k++)
      for (int c = 0; c < CPB_C[i]; c++)
        q.push_back('{lvl: b[k], fin: (k == b.size() - 1) && (c == CPB_C[i] - 1)});
  endtask

  // Called on the negedge of frame cycle 0; returns on the negedge after the last cycle.
  task automatic frame_check(input int i, input logic [15:0] bits, input int nb, input bit hold,
                             input bit nxt_v, input logic [8:0] nxt_d, input string tag);
    int len;
    len = nb * CPB_C[i];
    for (int k = 0; k < len; k++) begin
      check($sformatf("%s cyc%0d {line,busy,done,ready}", tag, k), 32'(obs(i)),
            32'({bits[k / CPB_C[i]], 1'b1, (k == len - 1), (k == len - 1)}));
      if (k == len - 1) begin
        valid[i] = nxt_v;
        data[i]  = nxt_d;
      end else if (!hold) begin
        valid[i] = 1'($urandom_range(0, 1));
        data[i]  = (k % 2 == 1) ? 9'h1FF : 9'($urandom);
      end
      @(negedge clk);
    end
  endtask

  task automatic send_vec(input vec_t v, input string tag);
    check({tag, " idle before"}, 32'(obs(v.inst)), 32'(4'b1001));
    valid[v.inst] = 1'b1;
    data[v.inst]  = v.dat;
    @(negedge clk);
    frame_check(v.inst, v.bits, v.nbits, 1'b0, 1'b0, 9'h000, tag);
    check({tag, " idle after"}, 32'(obs(v.inst)), 32'(4'b1001));
  endtask

  vec_t vecs[8];

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       v, r, acc, exp_rdy;
    logic [8:0] d;
    logic [3:0] exp;

    vecs[0] = '{0, 9'h0A5, 16'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{1, 9'h007, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11};
    vecs[2] = '{2, 9'h007, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11};
    vecs[3] = '{1, 9'h000, 16'({1'b1, 1'b0, 8'h00, 1'b0}), 11};
    vecs[4] = '{2, 9'h000, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11};
    vecs[5] = '{3, 9'h07F, 16'({2'b11, 7'h7F, 1'b0}), 10};
    vecs[6] = '{4, 9'h1A5, 16'({2'b11, 1'b0, 9'h1A5, 1'b0}), 13};
    vecs[7] = '{3, 9'h02A, 16'({2'b11, 7'h2A, 1'b0}), 10};

    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("reset inst%0d", i), 32'(obs(i)), 32'(4'b1000));
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("post-reset inst%0d", i), 32'(obs(i)), 32'(4'b1001));

    // Directed frame table
    for (int n = 0; n < 8; n++) send_vec(vecs[n], $sformatf("vec%0d", n));

    // Back-to-back with txValid held high
    check("b2b idle", 32'(obs(0)), 32'(4'b1001));
    valid[0] = 1'b1;
    data[0]  = 9'h055;
    @(negedge clk);
    frame_check(0, 16'({1'b1, 8'h55, 1'b0}), 10, 1'b1, 1'b1, 9'h0AA, "b2b first");
    frame_check(0, 16'({1'b1, 8'hAA, 1'b0}), 10, 1'b1, 1'b0, 9'h000, "b2b second");
    check("b2b idle after", 32'(obs(0)), 32'(4'b1001));

    // Reset during data bit 3
    valid[0] = 1'b1;
    data[0]  = 9'h0C3;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("rst-mid bit3 level", 32'(line_s[0]), 32'(1'b0));
    rst = 1'b0;
    #1 check("rst-mid ready low", 32'(ready_s[0]), 32'(1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst-mid held cyc%0d", k), 32'(obs(0)), 32'(4'b1000));
    end
    rst = 1'b1;
    @(negedge clk);
    send_vec('{0, 9'h03C, 16'({1'b1, 8'h3C, 1'b0}), 10}, "rst-mid fresh 3C");

    // Random traffic per configuration against the queue model
    for (int i = 0; i < NI; i++) begin
      q.delete();
      for (int c = 0; c < 500; c++) begin
        exp_rdy = rst && (q.size() == 0 || q[0].fin);
        exp = {(q.size() != 0) ? q[0].lvl : 1'b1, q.size() != 0,
               (q.size() != 0) ? q[0].fin : 1'b0, exp_rdy};
        check($sformatf("rand inst%0d cyc%0d", i, c), 32'(obs(i)), 32'(exp));
        v = (c < 420) && ($urandom_range(0, 3) != 0);
        d = 9'($urandom);
        r = (c >= 420) || ($urandom_range(0, 249) != 0);
        acc = r && v && (q.size() == 0 || q[0].fin);
        valid[i] = v;
        data[i]  = d;
        rst      = r;
        if (!r) begin
          q.delete();
        end else begin
          if (q.size() != 0) void'(q.pop_front());
          if (acc) push_frame(i, d);
        end
        @(negedge clk);
      end
      valid[i] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_transmitter.md
# param_transmitter

Parametrised UART transmit engine, the successor to the fixed 8N1 transmitter. It runs on the system clock with an internal bit-period divider instead of a separate baud clock. Data width, parity mode, stop-bit count and bit period are all configurable. It sits between the TX buffer, using a valid/ready handshake, and the FTDI UART pin, and it supports back-to-back frames with no idle gap.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-low reset; rst=0 at a rising clk edge resets the block.
- txValid  input  1  buffer has a byte for transmission.
- txData  input  DATA_BITS  byte to send; sampled only on acceptance.
- txReady  output  1  block can accept a byte this cycle.
- transmitOutput  output  1  serial line to the FTDI UART; idles high.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse at the end of each frame.

## Operation
- Acceptance happens on any rising edge where txValid=1 and txReady=1. At that edge, txData is latched into an internal shift register and the parity bit is computed from it. txData is not used again for that frame.
- States and their line levels:
  - IDLE: line = 1.
  - START: line = 0.
  - DATA: line = current data bit, LSB first.
  - PAR: line = parity bit.
  - STOP: line = 1.
- Transitions:
  - IDLE -> START on acceptance.
  - START -> DATA after one bit period.
  - DATA -> PAR after DATA_BITS bit periods if PARITY≠0; otherwise DATA -> STOP.
  - PAR -> STOP after one bit period.
  - STOP -> START if a new byte is accepted on its final cycle; otherwise STOP -> IDLE.
- Bit period: a baud counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state. A state or bit advances when the counter reaches CLKS_PER_BIT-1, and the counter then wraps to 0.
- Bit counter:
  - Width is $clog2(DATA_BITS).
  - In DATA it indexes bits 0..DATA_BITS-1.
  - In STOP it counts 0..STOP_BITS-1.
  - It clears on entry to each state.
- Parity bit:
  - Even mode: XOR of the data bits.
  - Odd mode: inverted XOR of the data bits.
- txReady:
  - 1 in IDLE.
  - 1 on the final clk cycle of the last stop bit.
  - 0 at all other times, including while rst=0.
- done is 1 on the final clk cycle of the last stop bit, whether or not a next byte is accepted.
- txValid outside txReady cycles is ignored and does not disturb the current frame.

## Timing
- Reset values (rst=0 at an edge):
  - State = IDLE, all counters = 0, shift register = 0.
  - transmitOutput = 1, busy = 0, done = 0.
  - txReady = 0 while rst is low; txReady = 1 on the first cycle after rst returns high.
- transmitOutput is registered, so it is glitch-free.
- Latency: the start bit appears on transmitOutput in the cycle after the acceptance edge.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
- Back-to-back frames: if a byte is accepted on the done cycle, the next start bit begins on the following cycle. There are zero idle cycles between frames.
- Reset mid-frame: the frame is aborted immediately. The line returns high on the next cycle, no done pulse is generated, and the partially sent byte is lost.
- txData may change at any time after acceptance without affecting the frame.

## Test plan
- 8N1, CLKS_PER_BIT=4, send 0xA5:
  - Line reads 0, 1,0,1,0,0,1,0,1, then 1, with each level held for 4 cycles (40 cycles total).
  - done pulses once, on cycle 40.
  - busy is 1 for 40 cycles.
- PARITY=2 (even), send 0x07: parity bit = 1. PARITY=1 (odd), send 0x07: parity bit = 0. With 0x00, even gives 0 and odd gives 1.
- STOP_BITS=2, DATA_BITS=7, send 0x7F: the line stays high for 2×CLKS_PER_BIT cycles after the data bits, and done is asserted only on the last of those cycles.
- Back-to-back: hold txValid=1 with 0x55 then 0xAA. The second start bit begins the cycle after the first frame's done, with no idle cycle, and txReady is 1 only in the acceptance cycles.
- Changing txValid/txData mid-frame (e.g. txData changed to 0xFF) has no effect on the current frame's bits.
- Drive rst=0 during data bit 3:
  - Next cycle: transmitOutput=1, busy=0, and done never pulses.
  - After rst returns high: txReady=1, and a fresh 0x3C frame transmits correctly.
